// File: rtl/pulse_accum_pkg.sv
// Shared definitions for the pulse accumulator: FSM state encoding and
// the default window length and count width.
package pulse_accum_pkg;

  localparam int WINDOW_CYCLES_DEF = 16;
  localparam int CNT_W_DEF         = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_accum_if.sv
// Detection-pulse input plus report handshake between the accumulator
// (slave) and whoever feeds pulses and consumes reports (master).
interface pulse_accum_if
  import pulse_accum_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             pulse_i;
  logic             ready_i;
  logic             valid_o;
  logic [CNT_W-1:0] cnt_o;
  logic             sat_o;
  logic             lost_o;

  modport master (
    output pulse_i, ready_i,
    input  valid_o, cnt_o, sat_o, lost_o
  );

  modport slave (
    input  pulse_i, ready_i,
    output valid_o, cnt_o, sat_o, lost_o
  );

endinterface

// File: rtl/pulse_accum_win_timer.sv
// Window timer: counts enabled cycles from zero; done flags the edge at
// which the count reaches WINDOW_CYCLES.
module win_timer
  import pulse_accum_pkg::*;
#(
  parameter int WINDOW_CYCLES = WINDOW_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [7:0] LAST = 8'(WINDOW_CYCLES - 1);

  logic [7:0] timer;

  // High during the cycle whose closing edge takes the timer to WINDOW_CYCLES.
  assign done = enable && (timer == LAST);

  // NOTE: sequential state uses non-blocking assignments; reset is sampled
  // on the clock edge (synchronous, active-low), so it sits inside the edge branch.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      timer <= '0;
    end else if (enable) begin
      timer <= timer + 8'd1;
    end
  end

endmodule

// File: rtl/pulse_accum.sv
// Counts detection pulses over a fixed window opened by the first pulse,
// then holds a saturating count report until the consumer accepts it.
module pulse_accum
  import pulse_accum_pkg::*;
#(
  parameter int WINDOW_CYCLES = WINDOW_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  pulse_accum_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             sat;
  logic [CNT_W-1:0] count_next;
  logic             sat_next;
  logic             done;

  win_timer #(.WINDOW_CYCLES(WINDOW_CYCLES)) u_win_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != COUNT),
    .enable (state == COUNT),
    .done   (done)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    count_next = count;
    sat_next   = sat;
    if (bus.pulse_i) begin
      if (count == CNT_MAX) sat_next = 1'b1;
      else                  count_next = count + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      sat         <= 1'b0;
      bus.valid_o <= 1'b0;
      bus.cnt_o   <= '0;
      bus.sat_o   <= 1'b0;
      bus.lost_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.pulse_i) begin
            state <= COUNT;
            count <= CNT_ONE;
            sat   <= 1'b0;
          end
        end

        COUNT: begin
          if (done) begin
            // The pulse sampled on the closing edge is part of the report.
            state       <= REPORT;
            bus.valid_o <= 1'b1;
            bus.cnt_o   <= count_next;
            bus.sat_o   <= sat_next;
            count       <= '0;
            sat         <= 1'b0;
          end else begin
            count <= count_next;
            sat   <= sat_next;
          end
        end

        REPORT: begin
          if (bus.ready_i) begin
            bus.valid_o <= 1'b0;
            bus.cnt_o   <= '0;
            bus.sat_o   <= 1'b0;
            count       <= '0;
            sat         <= 1'b0;
            // A pulse coinciding with the handshake opens the next window.
            if (bus.pulse_i) begin
              state <= COUNT;
              count <= CNT_ONE;
            end else begin
              state <= IDLE;
            end
          end else if (bus.pulse_i) begin
            bus.lost_o <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pulse_accum.md
PULSE_ACCUM -- requirements
Module: pulse_accum

Interface
REQ-001 The block SHALL have parameter WINDOW_CYCLES, default 16, giving the window length in cycles after the first pulse; legal range is 2..255.
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the width of the pulse count.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port pulse_i, input, 1 bit: single-cycle detection pulse from the upstream sequence-detector FSM.
REQ-006 The block SHALL have port ready_i, input, 1 bit: the consumer accepts the current report.
REQ-007 The block SHALL have port valid_o, output, 1 bit: a report is available.
REQ-008 The block SHALL have port cnt_o, output, CNT_W bits: the reported pulse count.
REQ-009 The block SHALL have port sat_o, output, 1 bit: the reported count saturated.
REQ-010 The block SHALL have port lost_o, output, 1 bit: sticky flag; a pulse arrived while a report was pending.

Function
REQ-011 The block SHALL implement FSM states IDLE, COUNT and REPORT, and all outputs SHALL be registered.
REQ-012 In IDLE, the block SHALL transition to COUNT on the edge E0 where pulse_i=1, loading count=1 and timer=0; in IDLE with pulse_i=0 it SHALL remain in IDLE.
REQ-013 In COUNT, the block SHALL increment the timer every edge and add pulse_i to count, saturating at 2^CNT_W-1.
REQ-014 When an increment is blocked by saturation, the block SHALL set the internal sat flag.
REQ-015 At the edge where the timer reaches WINDOW_CYCLES, including the pulse sampled at that edge, the block SHALL go to REPORT; cnt_o takes the count, sat_o takes the sat flag, and valid_o=1.
REQ-016 The counting window SHALL therefore cover edges E0..E(WINDOW_CYCLES), and valid_o SHALL rise WINDOW_CYCLES cycles after E0.
REQ-017 In REPORT, cnt_o and sat_o SHALL be held stable while valid_o=1 and ready_i=0.
REQ-018 At an edge in REPORT where ready_i=1, the block SHALL clear valid_o, clear the count and sat flag, and go to IDLE.
REQ-019 If pulse_i=1 at the same edge as the ready_i=1 handshake, the block SHALL go to COUNT with count=1 and timer=0, and no pulse SHALL be lost.
REQ-020 If pulse_i=1 in REPORT with ready_i=0, the pulse SHALL be discarded and lost_o SHALL be set to 1 and held until reset.
REQ-021 ready_i SHALL be ignored outside REPORT.
REQ-022 cnt_o and sat_o SHALL be 0 whenever valid_o=0.

Reset
REQ-023 On an edge with reset=0, the block SHALL go to IDLE and set valid_o=0, cnt_o=0, sat_o=0, lost_o=0, timer=0 and count=0, regardless of the other inputs.
REQ-024 Reset asserted mid-COUNT or mid-REPORT SHALL abort the window, and no report SHALL be produced for it.
REQ-025 After reset is released, the block SHALL behave as if just started, and the first edge with reset=1 SHALL be able to accept a pulse.

Structure
REQ-026 Package pulse_accum_pkg SHALL hold the state enum (IDLE, COUNT, REPORT) and the default values of WINDOW_CYCLES and CNT_W.
REQ-027 The window timer SHALL be a sub-module, win_timer, with clear and enable inputs and a done output asserted when the timer reaches WINDOW_CYCLES.
REQ-028 The count saturation logic and the FSM SHALL remain in pulse_accum.

Verification (bench parameters WINDOW_CYCLES=4, CNT_W=2 unless noted)
REQ-029 Scenario: reset=0 for 2 edges with pulse_i=1 and ready_i=1 -> valid_o=0, cnt_o=0, sat_o=0, lost_o=0, and the FSM stays in IDLE.
REQ-030 Scenario: pulses at E0 and E2, ready_i=1 -> valid_o=1 after E4 with cnt_o=2 and sat_o=0; valid_o=0 after E5.
REQ-031 Scenario: pulse every edge E0..E4 -> cnt_o=3 and sat_o=1 after E4.
REQ-032 Scenario: report pending, ready_i=0 for 3 edges, pulse at the 2nd of those edges -> cnt_o unchanged, lost_o=1; lost_o stays 1 after the handshake until reset.
REQ-033 Scenario: ready_i=1 and pulse_i=1 on the same edge in REPORT -> the next report arrives 4 cycles later with cnt_o of at least 1, and lost_o=0.
REQ-034 Scenario: pulse at E0, reset=0 at E2, pulse_i=0 thereafter -> valid_o never asserts and all outputs are 0.
